ex_div: RTL and testbench
=========================

EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 The block SHALL have a single clock, and its reset SHALL be synchronous and active-high.
REQ-002 The ports SHALL be:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- signed_div_i  in  1  1 = signed divide, 0 = unsigned divide.
- opdata1_i  in  32  dividend.
- opdata2_i  in  32  divisor.
- start_i  in  1  request from EX; held high until the result is consumed.
- annul_i  in  1  cancel the operation; held high from a flush or exception.
- result_o  out  64  result; [63:32] = remainder (HI), [31:0] = quotient (LO).
- ready_o  out  1  result valid.
- stallreq_o  out  1  pipeline stall request to the controller.

Function
REQ-003 The block SHALL implement the four states IDLE, BYZERO, ON and END, held in a 2-bit register.
REQ-004 IDLE: on start_i=1 with annul_i=0, the next state SHALL be BYZERO if opdata2_i==0, otherwise ON; the operands and signed_div_i SHALL be latched on that edge.
REQ-005 Operand capture: with signed_div_i=1, a negative operand SHALL be converted to its two's-complement magnitude before division.
REQ-006 ON: the block SHALL use restoring division, one quotient bit per rising edge, with a 6-bit iteration counter that runs 1..32.
REQ-007 Each iteration SHALL be a 33-bit trial subtraction of the divisor from {partial remainder, next dividend bit}; a non-negative difference SHALL shift in quotient bit 1 and keep the difference, otherwise quotient bit 0 and the old remainder.
REQ-008 On the edge after iteration 32, the block SHALL go ON->END and register result_o and ready_o=1, giving 33 edges from the edge that samples start_i to ready_o=1.
REQ-009 Sign fix-up, applied in that same edge:
- The quotient SHALL be negated when signed_div_i=1 and the operand signs differ.
- The remainder SHALL be negated when signed_div_i=1 and the dividend is negative.
REQ-010 BYZERO: the block SHALL go to END on the next edge with result_o=64'h0 and ready_o=1, a latency of 2 edges.
REQ-011 END: result_o and ready_o SHALL hold while start_i=1; on start_i=0 the block SHALL go to IDLE with ready_o=0 and result_o=0.
REQ-012 annul_i=1 SHALL force IDLE from any state on the next edge, with ready_o=0 and result_o=0 and the partial result discarded.
REQ-013 annul_i SHALL take priority over start_i, including when both are asserted in IDLE.
REQ-014 stallreq_o SHALL be combinational and equal 1 when start_i=1 and ready_o=0.
REQ-015 While the block is in ON, BYZERO or END, operand changes SHALL be ignored.
REQ-016 The most-negative dividend (32'h80000000) SHALL be handled via a 32-bit unsigned magnitude; -2^31 / -1 SHALL yield quotient 32'h80000000 and remainder 0.

Reset
REQ-017 With rst=1 at a rising edge, the block SHALL go to IDLE and clear result_o, ready_o, the counter, and the internal operand and remainder registers.
REQ-018 Reset SHALL take priority over annul_i and start_i, including in the middle of a division.
REQ-019 The cycle after rst deasserts SHALL be able to accept start_i.

Configuration
REQ-020 Macro DIV_SIGNED_EN SHALL control signed support.
- Defined: signed_div_i SHALL behave as specified in REQ-005 and REQ-009.
- Undefined: signed_div_i SHALL be ignored, all divides SHALL be unsigned, and the sign-conversion and fix-up logic SHALL be absent.
- Latency SHALL be identical in both builds.

Verification
REQ-021 The bench SHALL cover at least the following directed scenarios:
- Unsigned divide: opdata1=100, opdata2=7, start=1 -> ready_o=1 after 33 edges, result_o={32'd2, 32'd14}, stallreq_o=1 until then.
- Signed divide (DIV_SIGNED_EN defined): -7 / 2 -> result_o={32'hFFFFFFFF, 32'hFFFFFFFD}. With DIV_SIGNED_EN undefined, the same stimulus -> unsigned result {32'h1, 32'h7FFFFFFC}.
- Divide by zero: opdata2=0 -> ready_o=1 after 2 edges, result_o=64'h0; start dropped -> IDLE, ready_o=0 next edge.
- Annul: annul_i=1 at iteration 10 -> IDLE next edge, ready_o=0; a new start of 9 / 3 then gives result_o={32'd0, 32'd3}.
- Reset mid-op: rst=1 at iteration 20 -> all outputs 0, IDLE; a start on the cycle after reset is accepted.
- Hold in END: start_i held 5 extra cycles after ready -> result_o stable, ready_o=1, stallreq_o=0.

Source files
------------

// File: rtl/ex_div.sv
// ---------------------------------------------------------------------------
// ex_div -- iterative 32-bit divider for the EX stage.
//
// Produces one quotient bit per clock by restoring division. A divide takes
// 33 rising edges from the edge that accepts start_i up to and including the
// edge that raises ready_o. A divide by zero takes 2 edges and returns all
// zeros. The result stays valid while start_i is held high and is cleared
// once start_i drops.
//
// Build option:
//   DIV_SIGNED_EN - when defined, signed_div_i selects a signed divide.
//                   When undefined, every divide is unsigned and
//                   signed_div_i is ignored. Latency is the same in both
//                   builds.
//
// Ports:
//   clk          in   1   clock, rising edge
//   rst          in   1   synchronous reset, active-high
//   signed_div_i in   1   1 = signed divide, 0 = unsigned
//   opdata1_i    in  32   dividend
//   opdata2_i    in  32   divisor
//   start_i      in   1   request, held high until the result is consumed
//   annul_i      in   1   cancel the current operation (flush/exception)
//   result_o     out 64   {remainder (HI), quotient (LO)}
//   ready_o      out  1   result valid
//   stallreq_o   out  1   stall request while a result is still pending
// ---------------------------------------------------------------------------
module ex_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [31:0] dvdMag, dvsMag;
  logic [32:0] trial;
  logic [31:0] stepRem, stepQuo;
  logic [31:0] finalRem, finalQuo;

`ifdef DIV_SIGNED_EN
  logic negQuo_q, negQuo_d;
  logic negRem_q, negRem_d;
  logic dvdNeg, dvsNeg;

  // Signed operands are divided as magnitudes. The most-negative value maps
  // onto itself, which is exactly its magnitude when read as unsigned.
  assign dvdNeg = signed_div_i & opdata1_i[31];
  assign dvsNeg = signed_div_i & opdata2_i[31];
  assign dvdMag = dvdNeg ? (~opdata1_i + 32'd1) : opdata1_i;
  assign dvsMag = dvsNeg ? (~opdata2_i + 32'd1) : opdata2_i;
`else
  logic unusedSigned;

  assign unusedSigned = signed_div_i;
  assign dvdMag       = opdata1_i;
  assign dvsMag       = opdata2_i;
`endif

  // The dividend sits in quo_q and shifts out of its MSB while quotient bits
  // shift in at the LSB. The partial remainder is always below the divisor,
  // so bit 32 of the trial difference is set exactly when the subtraction
  // would go negative.
  assign trial   = {rem_q, quo_q[31]} - {1'b0, dvs_q};
  assign stepRem = trial[32] ? {rem_q[30:0], quo_q[31]} : trial[31:0];
  assign stepQuo = {quo_q[30:0], ~trial[32]};

`ifdef DIV_SIGNED_EN
  assign finalQuo = negQuo_q ? (~stepQuo + 32'd1) : stepQuo;
  assign finalRem = negRem_q ? (~stepRem + 32'd1) : stepRem;
`else
  assign finalQuo = stepQuo;
  assign finalRem = stepRem;
`endif

  // Next-state and datapath logic. Annul overrides everything except reset
  // and drops any partial result on the floor.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    ready_d  = ready_q;
`ifdef DIV_SIGNED_EN
    negQuo_d = negQuo_q;
    negRem_d = negRem_q;
`endif

    if (annul_i) begin
      state_d  = IDLE;
      cnt_d    = 6'd0;
      result_d = 64'h0;
      ready_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          result_d = 64'h0;
          ready_d  = 1'b0;
          if (start_i) begin
            cnt_d = 6'd1;
            rem_d = 32'h0;
            quo_d = dvdMag;
            dvs_d = dvsMag;
`ifdef DIV_SIGNED_EN
            negQuo_d = dvdNeg ^ dvsNeg;
            negRem_d = dvdNeg;
`endif
            state_d = (opdata2_i == 32'h0) ? BYZERO : ON;
          end
        end

        BYZERO: begin
          state_d  = END;
          result_d = 64'h0;
          ready_d  = 1'b1;
        end

        // The 32nd iteration and the sign fix-up share one edge so the
        // result lands on the 33rd edge after acceptance.
        ON: begin
          rem_d = stepRem;
          quo_d = stepQuo;
          if (cnt_q == 6'd32) begin
            state_d  = END;
            cnt_d    = 6'd0;
            result_d = {finalRem, finalQuo};
            ready_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end

        END: begin
          if (!start_i) begin
            state_d  = IDLE;
            result_d = 64'h0;
            ready_d  = 1'b0;
          end
        end

        default: begin
          state_d  = IDLE;
          result_d = 64'h0;
          ready_d  = 1'b0;
        end
      endcase
    end
  end

  // State register with synchronous reset taking priority over all inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      rem_q    <= 32'h0;
      quo_q    <= 32'h0;
      dvs_q    <= 32'h0;
      result_q <= 64'h0;
      ready_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
      negQuo_q <= 1'b0;
      negRem_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      ready_q  <= ready_d;
`ifdef DIV_SIGNED_EN
      negQuo_q <= negQuo_d;
      negRem_q <= negRem_d;
`endif
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = start_i & ~ready_q;

endmodule

// File: tb/tb_ex_div.sv
// ---------------------------------------------------------------------------
// tb_ex_div -- directed self-checking bench for ex_div.
//
// Expected results are hand-computed constants. Signed cases select their
// expectation with the same DIV_SIGNED_EN macro the design is built with.
// ---------------------------------------------------------------------------
module tb_ex_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int checks;
  int failures;
  int edges;

  ex_div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic sgn, input logic [31:0] a,
                               input logic [31:0] b, input logic st,
                               input logic an);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = st;
    annul_i      = an;
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until ready_o rises, giving up after maxEdges.
  task automatic waitReady(input int maxEdges, output int count);
    count = 0;
    do begin
      tick();
      count++;
    end while (!ready_o && count < maxEdges);
  endtask

  // Full transaction: start, latency, result, then release and return to idle.
  task automatic runDivide(input string tag, input logic sgn,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] expRes, input int expLat);
    int lat;
    applyStimulus(sgn, a, b, 1'b1, 1'b0);
    #1;
    checkOutput({tag, "_stall_pending"}, {63'h0, stallreq_o}, 64'h1);
    waitReady(40, lat);
    checkOutput({tag, "_latency"}, lat, expLat);
    checkOutput({tag, "_result"}, result_o, expRes);
    checkOutput({tag, "_stall_done"}, {63'h0, stallreq_o}, 64'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput({tag, "_ready_cleared"}, {63'h0, ready_o}, 64'h0);
    checkOutput({tag, "_result_cleared"}, result_o, 64'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset_result", result_o, 64'h0);
    checkOutput("reset_ready", {63'h0, ready_o}, 64'h0);
    checkOutput("reset_stall", {63'h0, stallreq_o}, 64'h0);
    rst = 1'b0;

    // 100 / 7 = 14 rem 2, watched edge by edge around the ready point.
    applyStimulus(1'b0, 32'd100, 32'd7, 1'b1, 1'b0);
    #1;
    checkOutput("u100_stall_start", {63'h0, stallreq_o}, 64'h1);
    repeat (32) tick();
    checkOutput("u100_ready_edge32", {63'h0, ready_o}, 64'h0);
    checkOutput("u100_stall_edge32", {63'h0, stallreq_o}, 64'h1);
    tick();
    checkOutput("u100_ready_edge33", {63'h0, ready_o}, 64'h1);
    checkOutput("u100_result", result_o, {32'd2, 32'd14});

    // Hold in END with changing operands; the result must not move.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 32'd55 + i, 32'd0, 1'b1, 1'b0);
      tick();
      checkOutput("hold_result", result_o, {32'd2, 32'd14});
      checkOutput("hold_ready", {63'h0, ready_o}, 64'h1);
      checkOutput("hold_stall", {63'h0, stallreq_o}, 64'h0);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("hold_release_ready", {63'h0, ready_o}, 64'h0);
    checkOutput("hold_release_result", result_o, 64'h0);

    // Unsigned edge cases.
    runDivide("u_small_dvd", 1'b0, 32'd3, 32'd10, {32'd3, 32'd0}, 33);
    runDivide("u_max_by1", 1'b0, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF}, 33);
    runDivide("u_deadbeef", 1'b0, 32'hDEADBEEF, 32'h1000, {32'h00000EEF, 32'h000DEADB}, 33);

    // Signed cases; the unsigned build treats the same bits as unsigned.
`ifdef DIV_SIGNED_EN
    runDivide("s_m7_by2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
    runDivide("s_7_bym2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 33);
    runDivide("s_min_bym1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33);
`else
    runDivide("s_m7_by2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'h1, 32'h7FFFFFFC}, 33);
    runDivide("s_7_bym2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'd7, 32'h0}, 33);
    runDivide("s_min_bym1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h0}, 33);
`endif
    runDivide("u_m7_by2_unsigned", 1'b0, 32'hFFFFFFF9, 32'd2, {32'h1, 32'h7FFFFFFC}, 33);

    // Divide by zero.
    runDivide("byzero", 1'b0, 32'd5, 32'd0, 64'h0, 2);

    // Annul mid-divide, then annul and start together in IDLE.
    applyStimulus(1'b0, 32'd1000, 32'd3, 1'b1, 1'b0);
    repeat (10) tick();
    applyStimulus(1'b0, 32'd1000, 32'd3, 1'b1, 1'b1);
    tick();
    checkOutput("annul_ready", {63'h0, ready_o}, 64'h0);
    checkOutput("annul_result", result_o, 64'h0);
    repeat (40) tick();
    checkOutput("annul_priority_ready", {63'h0, ready_o}, 64'h0);
    applyStimulus(1'b0, 32'd9, 32'd3, 1'b1, 1'b0);
    waitReady(40, edges);
    checkOutput("after_annul_latency", edges, 33);
    checkOutput("after_annul_result", result_o, {32'd0, 32'd3});
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();

    // Reset in the middle of a divide, then restart right after.
    applyStimulus(1'b0, 32'd50, 32'd5, 1'b1, 1'b0);
    repeat (20) tick();
    rst = 1'b1;
    tick();
    checkOutput("midreset_result", result_o, 64'h0);
    checkOutput("midreset_ready", {63'h0, ready_o}, 64'h0);
    rst = 1'b0;
    applyStimulus(1'b0, 32'd20, 32'd4, 1'b1, 1'b0);
    waitReady(40, edges);
    checkOutput("after_reset_latency", edges, 33);
    checkOutput("after_reset_result", result_o, {32'd0, 32'd5});
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("after_reset_release", {63'h0, ready_o}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
